instruction_encoder: RTL
========================

Name: instruction_encoder

Overview:
- Inverse of the immediate generator: packs register fields and a 64-bit signed immediate into a 32-bit RV64 I/S/B instruction word.
- Feeds the instruction-memory loader and self-checking benches, where encoded words are decoded back by the immediate generator.
- Single registered output stage with valid/ready handshake, immediate range and opcode legality checks, and a running store address (PC) counter.

Parameters:
- PC_BASE, 64'h0, address assigned to the first emitted instruction after reset.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- fmt  input  2  0=I, 1=S, 2=B, 3=reserved
- opcode  input  7  major opcode
- funct3  input  3  funct3 field
- rd  input  5  destination register (I only)
- rs1  input  5  source register 1
- rs2  input  5  source register 2 (S/B only)
- imm  input  64  signed immediate, byte offset for B
- out_valid  output  1  instr/pc/err valid
- out_ready  input  1  consumer accepts output
- instr  output  32  encoded instruction, 0 on error
- pc  output  64  address tagged to this output
- err  output  1  request illegal; instr forced to 0
- err_count  output  ERR_CNT_W  saturating count of emitted errors

Behaviour:
- Reset (async, any time, including mid-transfer): out_valid=0, instr=0, pc=PC_BASE, err=0, err_count=0, internal next-PC=PC_BASE. Any pending output is dropped.
- in_ready = !out_valid || out_ready. This is combinational and allows full throughput.
- Accept when in_valid && in_ready. Outputs are registered on that edge, giving 1-cycle latency.
- out_valid remains high until out_valid && out_ready. While stalled, instr, pc and err hold stable.
- If acceptance and output handshake happen in the same cycle, the new entry replaces the old one with no bubble.
- Legality checks:
  - I: opcode in {0010011, 0000011, 1100111}; imm[63:11] all equal (fits signed 12).
  - S: opcode = 0100011; imm fits signed 12.
  - B: opcode = 1100011; imm[63:12] all equal (fits signed 13) and imm[0] = 0.
  - fmt=3 is always illegal.
- Encoding, for legal requests:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- Illegal requests: instr=0 and err=1. They are still emitted and still require a handshake.
- PC rules:
  - pc is the next-PC value captured at acceptance.
  - next-PC += 4 only for legal accepted requests. An error does not consume an address.
  - next-PC wraps modulo 2^64.
- err_count increments on acceptance of an illegal request and saturates at all-ones.
- No internal state machine beyond the valid bit. There are two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on output handshake with no accept.
  - FULL→FULL on accept with handshake, or on stall.

Decomposition:
- Shared package `riscv_isa_pkg` holds:
  - fmt encodings FMT_I/FMT_S/FMT_B/FMT_RSV.
  - Opcode constants OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH.
  - These are the same constants the immediate generator switches on.
- One combinational sub-module, `imm_field_packer`:
  - Inputs: fmt, fields and imm.
  - Outputs: instr_comb and illegal.
- The top level holds only the handshake register, PC and error counter.

Test Plan:
- I-type: fmt=0, op=0010011, f3=0, rd=1, rs1=0, imm=10 → instr=32'h00A00093, err=0, pc=0. Then imm=-5 → 32'hFFB00093, pc=4.
- S-type: fmt=1, op=0100011, f3=3, rs1=0, rs2=3, imm=16 → 32'h00303823, err=0.
- B-type: fmt=2, op=1100011, f3=0, rs1=1, rs2=2, imm=8 → 32'h00208463. Feeding the result to immediate_generator returns imm=8, as does the I/S round-trip.
- Illegal requests:
  - I with imm=2048 → instr=0, err=1.
  - B with imm=7 → err=1.
  - fmt=3 → err=1.
  - After these, err_count=3 and next-PC is unchanged; the following legal instr gets pc=8.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, outputs stable. Release → one word per cycle with back-to-back pcs 0, 4, 8.
- Reset asserted asynchronously mid-stall → out_valid drops immediately; pc restarts at PC_BASE; err_count=0.

Source files
------------

// File: rtl/riscv_isa_pkg.sv
// Shared RV64 ISA constants: instruction format selectors, major opcodes and
// immediate range helpers used by the encoder (and mirrored by the immediate generator).
package riscv_isa_pkg;

    typedef enum logic [1:0] {
        FMT_I   = 2'd0,
        FMT_S   = 2'd1,
        FMT_B   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Output stage occupancy; visible as a named signal for checkers.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } enc_state_e;

    // True when every bit above bit 11 is a copy of bit 11.
    function automatic logic fits_s12(input logic [63:0] v);
        return v[63:11] == {53{v[11]}};
    endfunction

    function automatic logic fits_s13(input logic [63:0] v);
        return v[63:12] == {52{v[12]}};
    endfunction

endpackage

// File: rtl/imm_field_packer.sv
// Combinational packing of register fields and a signed immediate into an
// I/S/B instruction word, with opcode and immediate-range legality checks.
module imm_field_packer
    import riscv_isa_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic [31:0] instr_comb,
    output logic        illegal
);

    logic [31:0] word;

    always_comb begin
        word    = '0;
        illegal = 1'b1;
        case (fmt_e'(fmt))
            FMT_I: begin
                illegal = !((opcode == OP_IMM) || (opcode == OP_LOAD) || (opcode == OP_JALR))
                          || !fits_s12(imm);
                word    = {imm[11:0], rs1, funct3, rd, opcode};
            end
            FMT_S: begin
                illegal = (opcode != OP_STORE) || !fits_s12(imm);
                word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            FMT_B: begin
                // Branch offsets are halfword aligned; bit 0 is not encodable.
                illegal = (opcode != OP_BRANCH) || !fits_s13(imm) || imm[0];
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            default: begin
                illegal = 1'b1;
                word    = '0;
            end
        endcase
    end

    assign instr_comb = illegal ? 32'd0 : word;

endmodule

// File: rtl/instruction_encoder.sv
// Registered instruction encoder: one output slot with valid/ready handshake,
// a running PC for legal words and a saturating error counter.
module instruction_encoder
    import riscv_isa_pkg::*;
#(
    parameter logic [63:0] PC_BASE   = 64'h0,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [63:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic [63:0]          pc,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; out_valid/instr/pc/err hold until the consumer takes them.
    enc_state_e  state_q, state_d;
    logic        accept;
    logic [31:0] instr_comb;
    logic        illegal;
    logic [63:0] next_pc;

    imm_field_packer u_packer (
        .fmt        (fmt),
        .opcode     (opcode),
        .funct3     (funct3),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .instr_comb (instr_comb),
        .illegal    (illegal)
    );

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr     <= '0;
            pc        <= PC_BASE;
            err       <= 1'b0;
            err_count <= '0;
            next_pc   <= PC_BASE;
        end else if (accept) begin
            instr <= instr_comb;
            pc    <= next_pc;
            err   <= illegal;
            // Rejected requests are reported but do not occupy an address.
            if (!illegal) begin
                next_pc <= next_pc + 64'd4;
            end else if (err_count != {ERR_CNT_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
